if_fetch_stage: RTL and testbench

Instruction fetch stage: the producer of the `instr`/`addr_instr` pair consumed by the decode stage. It owns the PC, issues in-order word requests to instruction memory over a request/grant and response handshake, and buffers up to `FIFO_DEPTH` outstanding or returned words. It drives the IF/ID pipeline register, and it honours the shared hold code and redirects from resolved jumps and branches.

---
 rtl/if_fetch_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues in-order word requests over a req/gnt + rvalid
// handshake, buffers up to FIFO_DEPTH outstanding or returned words in a
// slot ring, and drops responses that belong to fetches squashed by a redirect.
// Optional feature macro: IF_MISALIGN_EXCEPT_EN adds fetch_except_o and a
// stopped state entered on a misaligned redirect target.
module if_fetch_stage #(
   parameter int                ADDR_W       = 64,
   parameter int                DATA_W       = 32,
   parameter int                HOLD_W       = 3,
   parameter logic [HOLD_W-1:0] HOLD_CODE_IF = 3'd1,
   parameter logic [ADDR_W-1:0] RESET_PC     = 64'h0000_0000_8000_0000,
   parameter int                FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HOLD_W-1:0] hold_code_i,
   input  logic              jmp_flag_i,
   input  logic [ADDR_W-1:0] jmp_addr_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] addr_instr_o,
   output logic              instr_valid_o
`ifdef IF_MISALIGN_EXCEPT_EN
  ,output logic              fetch_except_o
`endif
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   // Stale responses accumulate across back-to-back redirects; extra headroom
   // beyond one ring's worth keeps the counter from wrapping.
   localparam int DISC_W = PTR_W + 4;
   localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      filled_cnt_q, filled_cnt_d;
   logic [DISC_W-1:0]     discard_q, discard_d;
   logic [ADDR_W-1:0]     slot_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0]     slot_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] slot_filled_q;
   logic [DATA_W-1:0]     instr_q, instr_d;
   logic [ADDR_W-1:0]     addr_instr_q, addr_instr_d;
   logic                  valid_q, valid_d;

   // ------------------------------------------------------------------
   // Decoded per-cycle events
   // ------------------------------------------------------------------
   logic              hold;
   logic              stop_blk;
   logic [ADDR_W-1:0] jmp_tgt;
   logic              alloc;
   logic              fill;
   logic              pop;
   logic [CNT_W-1:0]  unfilled;
   logic [PTR_W-1:0]  fill_idx;
   logic [DISC_W-1:0] disc_sum;

   assign hold = (hold_code_i >= HOLD_CODE_IF);

`ifdef IF_MISALIGN_EXCEPT_EN
   logic stopped_q, stopped_d;
   logic except_q, except_d;
   logic misalign;

   assign jmp_tgt        = jmp_addr_i;
   assign misalign       = (jmp_tgt[1:0] != 2'b00);
   assign stop_blk       = stopped_q;
   assign fetch_except_o = except_q;
`else
   // Without the exception feature the low address bits are simply ignored.
   assign jmp_tgt  = jmp_addr_i & ~ADDR_W'(3);
   assign stop_blk = 1'b0;
`endif

   assign mem_req_o  = !rst && !jmp_flag_i && (count_q < CNT_W'(FIFO_DEPTH)) && !stop_blk;
   assign mem_addr_o = pc_q;
   assign alloc      = mem_req_o && mem_gnt_i;

   // Filled slots are always a contiguous run starting at head, so the
   // oldest unfilled slot sits filled_cnt entries past head.
   assign unfilled = count_q - filled_cnt_q;
   assign fill_idx = head_q + filled_cnt_q[PTR_W-1:0];
   assign fill     = mem_rvalid_i && (discard_q == '0) && (unfilled != '0) && !jmp_flag_i;
   assign pop      = !jmp_flag_i && !hold && slot_filled_q[head_q];

   // Every slot still waiting for data at a redirect becomes a stale response.
   assign disc_sum = discard_q + DISC_W'(unfilled);

   assign instr_o       = instr_q;
   assign addr_instr_o  = addr_instr_q;
   assign instr_valid_o = valid_q;

   // Next-state for PC, ring pointers/counters, discard counter and IF/ID.
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the branches below can leave one unassigned and infer a latch.
      pc_d         = pc_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      filled_cnt_d = filled_cnt_q;
      discard_d    = discard_q;
      instr_d      = instr_q;
      addr_instr_d = addr_instr_q;
      valid_d      = valid_q;
`ifdef IF_MISALIGN_EXCEPT_EN
      stopped_d    = stopped_q;
      except_d     = except_q;
`endif
      if (jmp_flag_i) begin
         // Redirect wins over hold and pop; a response this cycle is dropped.
         pc_d         = jmp_tgt;
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         filled_cnt_d = '0;
         discard_d    = (mem_rvalid_i && (disc_sum != '0)) ? disc_sum - DISC_W'(1) : disc_sum;
         instr_d      = NOP_INSTR;
         valid_d      = 1'b0;
`ifdef IF_MISALIGN_EXCEPT_EN
         stopped_d    = misalign;
         except_d     = misalign;
         if (misalign) begin
            addr_instr_d = jmp_tgt;
         end
`endif
      end else begin
         if (alloc) begin
            pc_d   = pc_q + ADDR_W'(4);
            tail_d = tail_q + PTR_W'(1);
         end
         if (mem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - DISC_W'(1);
         end
         count_d      = count_q + CNT_W'(alloc) - CNT_W'(pop);
         filled_cnt_d = filled_cnt_q + CNT_W'(fill) - CNT_W'(pop);
         if (pop) begin
            head_d       = head_q + PTR_W'(1);
            instr_d      = slot_data_q[head_q];
            addr_instr_d = slot_addr_q[head_q];
            valid_d      = 1'b1;
         end else if (!hold) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   // Control and IF/ID registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (rst) begin
         pc_q         <= RESET_PC;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         filled_cnt_q <= '0;
         discard_q    <= '0;
         instr_q      <= NOP_INSTR;
         addr_instr_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         filled_cnt_q <= filled_cnt_d;
         discard_q    <= discard_d;
         instr_q      <= instr_d;
         addr_instr_q <= addr_instr_d;
         valid_q      <= valid_d;
      end
   end

`ifdef IF_MISALIGN_EXCEPT_EN
   // Misaligned-redirect flag and the request block that goes with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stopped_q <= 1'b0;
         except_q  <= 1'b0;
      end else begin
         stopped_q <= stopped_d;
         except_q  <= except_d;
      end
   end
`endif

   // Per-slot filled flags; cleared wholesale by reset and by redirect.
   always_ff @(posedge clk) begin
      if (rst || jmp_flag_i) begin
         slot_filled_q <= '0;
      end else begin
         if (alloc) begin
            slot_filled_q[tail_q] <= 1'b0;
         end
         if (fill) begin
            slot_filled_q[fill_idx] <= 1'b1;
         end
         if (pop) begin
            slot_filled_q[head_q] <= 1'b0;
         end
      end
   end

   // Slot payload storage: address on allocate, data on response.
   always_ff @(posedge clk) begin
      // NOTE: the payload arrays have no reset; a slot is only read after its
      // filled flag is set, and that flag is reset.
      if (alloc) begin
         slot_addr_q[tail_q] <= pc_q;
      end
      if (fill) begin
         slot_data_q[fill_idx] <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage. A small in-order
// memory responder answers each granted fetch one cycle later (when enabled)
// with word = (addr[17:2] + 1). Covers the IF_MISALIGN_EXCEPT_EN build too.
module tb_if_fetch_stage;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  hold_code_i;
   logic        jmp_flag_i;
   logic [63:0] jmp_addr_i;
   logic        mem_req_o;
   logic [63:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] instr_o;
   logic [63:0] addr_instr_o;
   logic        instr_valid_o;
`ifdef IF_MISALIGN_EXCEPT_EN
   logic        fetch_except_o;
`endif

   if_fetch_stage #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hold_code_i  (hold_code_i),
      .jmp_flag_i   (jmp_flag_i),
      .jmp_addr_i   (jmp_addr_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .instr_o      (instr_o),
      .addr_instr_o (addr_instr_o),
      .instr_valid_o(instr_valid_o)
`ifdef IF_MISALIGN_EXCEPT_EN
     ,.fetch_except_o(fetch_except_o)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          grants = 0;
   bit          resp_en = 1'b0;
   logic [63:0] pend[$];
   int          g0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i, input logic [63:0] a);
      check({tag, ".valid"}, 64'(instr_valid_o), 64'(v));
      check({tag, ".instr"}, 64'(instr_o), 64'(i));
      check({tag, ".addr"}, addr_instr_o, a);
   endtask

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return {16'h0, a[17:2]} + 32'd1;
   endfunction

   // One clock: record the handshake seen before the edge, then present the
   // next response (if any) at the falling edge.
   task automatic cyc();
      logic        g, rv, r;
      logic [63:0] ga, dropped;
      #1;
      g  = mem_req_o && mem_gnt_i;
      ga = mem_addr_o;
      rv = mem_rvalid_i;
      r  = rst;
      @(posedge clk);
      if (r) begin
         pend.delete();
      end else begin
         if (rv && pend.size() > 0) dropped = pend.pop_front();
         if (g) begin
            pend.push_back(ga);
            grants++;
         end
      end
      @(negedge clk);
      if (resp_en && !rst && pend.size() > 0) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = word_of(pend[0]);
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; hold_code_i = 3'd0; jmp_flag_i = 1'b0; jmp_addr_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      // ---------------- reset ----------------
      cycles(2);
      chk_ifid("reset", 1'b0, 32'h0000_0013, 64'h0);
      check("reset.req", 64'(mem_req_o), 64'd0);
      check("reset.mem_addr", mem_addr_o, 64'h8000_0000);
`ifdef IF_MISALIGN_EXCEPT_EN
      check("reset.except", 64'(fetch_except_o), 64'd0);
`endif

      // ---------------- cold start + streaming ----------------
      rst = 1'b0; mem_gnt_i = 1'b1; resp_en = 1'b1;
      #1;
      check("cold.req", 64'(mem_req_o), 64'd1);
      check("cold.mem_addr", mem_addr_o, 64'h8000_0000);
      cyc(); check("cold.e0.valid", 64'(instr_valid_o), 64'd0);
      cyc(); check("cold.e1.valid", 64'(instr_valid_o), 64'd0);
      cyc(); chk_ifid("cold.e2", 1'b1, 32'h1, 64'h8000_0000);
      for (int k = 1; k < 8; k++) begin
         cyc();
         chk_ifid("stream", 1'b1, 32'(k + 1), 64'h8000_0000 + 64'(4 * k));
      end

      // ---------------- drain to empty ----------------
      mem_gnt_i = 1'b0;
      cyc(); chk_ifid("drain0", 1'b1, 32'h9, 64'h8000_0020);
      cyc(); chk_ifid("drain1", 1'b1, 32'ha, 64'h8000_0024);
      cyc(); chk_ifid("empty", 1'b0, 32'h0000_0013, 64'h8000_0024);

      // ---------------- hold until full ----------------
      hold_code_i = 3'd1; mem_gnt_i = 1'b1;
      g0 = grants;
      cycles(10);
      check("hold.grants", 64'(grants - g0), 64'd4);
      check("hold.req_full", 64'(mem_req_o), 64'd0);
      check("hold.mem_addr", mem_addr_o, 64'h8000_0038);
      chk_ifid("hold.frozen", 1'b0, 32'h0000_0013, 64'h8000_0024);
      hold_code_i = 3'd0;
      #1;
      check("release.req_still_full", 64'(mem_req_o), 64'd0);
      cyc(); chk_ifid("release0", 1'b1, 32'hb, 64'h8000_0028);
      check("release.req_back", 64'(mem_req_o), 64'd1);
      cyc(); chk_ifid("release1", 1'b1, 32'hc, 64'h8000_002c);
      cyc(); chk_ifid("release2", 1'b1, 32'hd, 64'h8000_0030);
      cyc(); chk_ifid("release3", 1'b1, 32'he, 64'h8000_0034);
      cyc(); chk_ifid("release4", 1'b1, 32'hf, 64'h8000_0038);

      // ---------------- redirect with 3 in-flight ----------------
      rst = 1'b1; mem_gnt_i = 1'b0; resp_en = 1'b0;
      cyc();
      rst = 1'b0; mem_gnt_i = 1'b1;
      cycles(3);
      check("inflight.valid", 64'(instr_valid_o), 64'd0);
      jmp_flag_i = 1'b1; jmp_addr_i = 64'h8000_0100;
      #1;
      check("redir.req_blocked", 64'(mem_req_o), 64'd0);
      resp_en = 1'b1;
      cyc();
      jmp_flag_i = 1'b0;
      chk_ifid("redir.nop", 1'b0, 32'h0000_0013, 64'h0);
      check("redir.mem_addr", mem_addr_o, 64'h8000_0100);
      #1;
      check("redir.req", 64'(mem_req_o), 64'd1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("redir.stale_dropped", 64'(instr_valid_o), 64'd0);
      end
      cyc(); chk_ifid("redir.target", 1'b1, 32'h41, 64'h8000_0100);
      cyc(); chk_ifid("redir.next", 1'b1, 32'h42, 64'h8000_0104);

      // ------- redirect under hold with a simultaneous response -------
      check("holdredir.rvalid_present", 64'(mem_rvalid_i), 64'd1);
      hold_code_i = 3'd2; jmp_flag_i = 1'b1; jmp_addr_i = 64'h8000_0200;
      cyc();
      jmp_flag_i = 1'b0;
      check("holdredir.valid", 64'(instr_valid_o), 64'd0);
      check("holdredir.instr", 64'(instr_o), 64'h13);
      check("holdredir.mem_addr", mem_addr_o, 64'h8000_0200);
      #1;
      check("holdredir.req", 64'(mem_req_o), 64'd1);
      cyc(); check("holdredir.held_nop", 64'(instr_valid_o), 64'd0);
      hold_code_i = 3'd0;
      cyc(); check("holdredir.wait", 64'(instr_valid_o), 64'd0);
      cyc(); chk_ifid("holdredir.target", 1'b1, 32'h81, 64'h8000_0200);

      // ---------------- misaligned redirect ----------------
      jmp_flag_i = 1'b1; jmp_addr_i = 64'h8000_0102;
      cyc();
      jmp_flag_i = 1'b0;
`ifdef IF_MISALIGN_EXCEPT_EN
      check("misal.except", 64'(fetch_except_o), 64'd1);
      chk_ifid("misal.ifid", 1'b0, 32'h0000_0013, 64'h8000_0102);
      #1;
      check("misal.req", 64'(mem_req_o), 64'd0);
      g0 = grants;
      cycles(3);
      check("misal.no_grants", 64'(grants - g0), 64'd0);
      check("misal.req_stopped", 64'(mem_req_o), 64'd0);
      jmp_flag_i = 1'b1; jmp_addr_i = 64'h8000_0200;
      cyc();
      jmp_flag_i = 1'b0;
      check("misal.cleared", 64'(fetch_except_o), 64'd0);
      #1;
      check("misal.resume_req", 64'(mem_req_o), 64'd1);
      check("misal.resume_addr", mem_addr_o, 64'h8000_0200);
      cyc();
      cyc(); check("misal.wait", 64'(instr_valid_o), 64'd0);
      cyc(); chk_ifid("misal.target", 1'b1, 32'h81, 64'h8000_0200);
`else
      check("align.mem_addr", mem_addr_o, 64'h8000_0100);
      #1;
      check("align.req", 64'(mem_req_o), 64'd1);
      cyc(); check("align.drop", 64'(instr_valid_o), 64'd0);
      cyc(); check("align.wait", 64'(instr_valid_o), 64'd0);
      cyc(); chk_ifid("align.target", 1'b1, 32'h41, 64'h8000_0100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
